branch_target_predictor: RTL and testbench



---
 rtl/branch_target_predictor.sv | 124 ++++++++++++
 tb/tb_branch_target_predictor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Fetch-stage direct-mapped BTB with 2-bit saturating direction counters and one training port.
// Optional performance counters are enabled by defining BTP_PERF_CNT_EN.
module branch_target_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter int         TAG_BITS   = 8,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [1:0]  pred_src,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict
`ifdef BTP_PERF_CNT_EN
  ,
  output logic [31:0] perf_branch_cnt,
  output logic [31:0] perf_mispred_cnt
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LSB = INDEX_BITS + 2;
  localparam int TAG_MSB = TAG_LSB + TAG_BITS - 1;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [1:0]          ctr_q [ENTRIES];
  logic [1:0]          ctr_d [ENTRIES];
  logic [TAG_BITS-1:0] tag_mem_q [ENTRIES];
  logic [31:0]         target_mem_q [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx, upd_idx;
  logic [TAG_BITS-1:0]   fetch_tag, upd_tag;
  logic                  fetch_hit, upd_hit;
  logic                  tag_we, target_we;

  assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag = fetch_pc[TAG_MSB:TAG_LSB];
  assign upd_idx   = upd_pc[INDEX_BITS+1:2];
  assign upd_tag   = upd_pc[TAG_MSB:TAG_LSB];

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign fetch_hit   = fetch_valid & valid_q[fetch_idx] & (tag_mem_q[fetch_idx] == fetch_tag);
  assign pred_taken  = fetch_hit & ctr_q[fetch_idx][1];
  assign pred_target = pred_taken ? target_mem_q[fetch_idx] : 32'h0;
  assign pred_src    = pred_taken ? 2'b10 : 2'b00;

  assign upd_hit   = valid_q[upd_idx] & (tag_mem_q[upd_idx] == upd_tag);
  assign tag_we    = upd_valid & upd_taken & ~upd_hit;
  assign target_we = upd_valid & upd_taken;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < ENTRIES; i++) ctr_d[i] = ctr_q[i];
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
        end else begin
          if (ctr_q[upd_idx] != 2'b00) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx] = 1'b1;
        ctr_d[upd_idx]   = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= ctr_d[i];
    end
  end

  // Tags and targets need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (tag_we)    tag_mem_q[upd_idx]    <= upd_tag;
    if (target_we) target_mem_q[upd_idx] <= upd_target;
  end

`ifdef BTP_PERF_CNT_EN
  logic [31:0] perf_branch_cnt_q, perf_branch_cnt_d;
  logic [31:0] perf_mispred_cnt_q, perf_mispred_cnt_d;

  always_comb begin
    perf_branch_cnt_d  = perf_branch_cnt_q;
    perf_mispred_cnt_d = perf_mispred_cnt_q;
    if (upd_valid) begin
      perf_branch_cnt_d = perf_branch_cnt_q + 32'd1;
      if (upd_mispredict) perf_mispred_cnt_d = perf_mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branch_cnt_q  <= '0;
      perf_mispred_cnt_q <= '0;
    end else begin
      perf_branch_cnt_q  <= perf_branch_cnt_d;
      perf_mispred_cnt_q <= perf_mispred_cnt_d;
    end
  end

  assign perf_branch_cnt  = perf_branch_cnt_q;
  assign perf_mispred_cnt = perf_mispred_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], fetch_pc[31:TAG_MSB+1], upd_pc[1:0], upd_pc[31:TAG_MSB+1]};
`else
  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], fetch_pc[31:TAG_MSB+1], upd_pc[1:0], upd_pc[31:TAG_MSB+1],
                         upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: expected predictions are queued when a fetch
// is driven and popped/compared once the combinational outputs have settled.
module tb_branch_target_predictor;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_src;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
`ifdef BTP_PERF_CNT_EN
  logic [31:0] perf_branch_cnt;
  logic [31:0] perf_mispred_cnt;
`endif

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    string       name;
    logic [34:0] exp;
  } exp_t;

  exp_t sb_q[$];

  branch_target_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_src       (pred_src),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict)
`ifdef BTP_PERF_CNT_EN
    ,
    .perf_branch_cnt  (perf_branch_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pred(input string name, input logic t, input logic [31:0] tgt);
    exp_t e;
    e.name = name;
    e.exp  = {t, (t ? 2'b10 : 2'b00), (t ? tgt : 32'h0)};
    sb_q.push_back(e);
  endtask

  task automatic check_pred();
    exp_t        e;
    logic [34:0] obs;
    obs = {pred_taken, pred_src, pred_target};
    total_cnt = total_cnt + 1;
    if (sb_q.size() == 0) begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL scoreboard_empty observed=%h required=none", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) begin
      pass_cnt = pass_cnt + 1;
      $display("check %s: taken/src/target=%h ok", e.name, obs);
    end else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%h required=%h", e.name, obs, e.exp);
    end
  endtask

  // Drive one fetch inside the current cycle and compare before the next edge.
  task automatic look(input string name, input logic [31:0] pc, input logic t,
                      input logic [31:0] tgt);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    expect_pred(name, t, tgt);
    #2;
    check_pred();
    fetch_valid = 1'b0;
    fetch_pc    = 32'h0;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = mis;
    step();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    $display("update pc=%h taken=%0d target=%h mispredict=%0d", pc, taken, tgt, mis);
  endtask

`ifdef BTP_PERF_CNT_EN
  task automatic check_cnt(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) begin
      pass_cnt = pass_cnt + 1;
      $display("check %s: %h ok", name, obs);
    end else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%h required=%h", name, obs, exp);
    end
  endtask
`endif

  initial begin
    rst_n          = 1'b0;
    fetch_valid    = 1'b0;
    fetch_pc       = 32'h0;
    upd_valid      = 1'b0;
    upd_pc         = 32'h0;
    upd_taken      = 1'b0;
    upd_target     = 32'h0;
    upd_mispredict = 1'b0;

    #1;
    look("in_reset", 32'h0000_0100, 1'b0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    look("cold_miss", 32'h0000_0100, 1'b0, 32'h0);
    do_upd(32'h100, 1'b1, 32'h200, 1'b0);
    look("alloc_hit", 32'h0000_0100, 1'b1, 32'h200);

    do_upd(32'h100, 1'b0, 32'h0, 1'b1);
    look("ctr_01", 32'h0000_0100, 1'b0, 32'h0);
    do_upd(32'h100, 1'b0, 32'h0, 1'b1);
    look("ctr_00", 32'h0000_0100, 1'b0, 32'h0);

    do_upd(32'h100, 1'b1, 32'h240, 1'b1);
    look("ctr_up_01", 32'h0000_0100, 1'b0, 32'h0);
    do_upd(32'h100, 1'b1, 32'h240, 1'b1);
    look("ctr_up_10", 32'h0000_0100, 1'b1, 32'h240);

    for (int i = 0; i < 3; i++) do_upd(32'h100, 1'b1, 32'h240, 1'b0);
    look("ctr_sat_11", 32'h0000_0100, 1'b1, 32'h240);
    do_upd(32'h100, 1'b0, 32'h0, 1'b1);
    look("sat_then_nt", 32'h0000_0100, 1'b1, 32'h240);

    look("alias_miss", 32'h0000_0500, 1'b0, 32'h0);
    expect_pred("fetch_invalid", 1'b0, 32'h0);
    fetch_valid = 1'b0;
    fetch_pc    = 32'h0000_0100;
    #2;
    check_pred();

    do_upd(32'h500, 1'b1, 32'h800, 1'b0);
    look("replaced_hit", 32'h0000_0500, 1'b1, 32'h800);
    look("evicted_miss", 32'h0000_0100, 1'b0, 32'h0);

    do_upd(32'h104, 1'b0, 32'h900, 1'b0);
    look("nt_miss_noalloc", 32'h0000_0104, 1'b0, 32'h0);
    look("low_bits_ignored", 32'h0000_0503, 1'b1, 32'h800);

    do_upd(32'h1234_5678, 1'b1, 32'hDEAD_BEEC, 1'b0);
    look("other_idx_hit", 32'h1234_5678, 1'b1, 32'hDEAD_BEEC);
    look("upper_bits_alias", 32'hABCD_5678, 1'b1, 32'hDEAD_BEEC);

    look("pre_async_rst", 32'h0000_0500, 1'b1, 32'h800);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_0500;
    expect_pred("async_rst_drop", 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_pred();
    fetch_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    look("after_rst_miss", 32'h0000_0500, 1'b0, 32'h0);

    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_taken  = 1'b1;
    upd_target = 32'h700;
    rst_n      = 1'b0;
    step();
    upd_valid = 1'b0;
    rst_n     = 1'b1;
    step();
    look("upd_in_rst_dropped", 32'h0000_0100, 1'b0, 32'h0);

    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_taken  = 1'b1;
    upd_target = 32'h300;
    look("same_cycle_no_bypass", 32'h0000_0100, 1'b0, 32'h0);
    step();
    upd_valid = 1'b0;
    look("same_cycle_next", 32'h0000_0100, 1'b1, 32'h300);

`ifdef BTP_PERF_CNT_EN
    rst_n = 1'b0;
    #1;
    check_cnt("perf_branch_rst", perf_branch_cnt, 32'd0);
    check_cnt("perf_mispred_rst", perf_mispred_cnt, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    do_upd(32'h100, 1'b1, 32'h300, 1'b1);
    do_upd(32'h104, 1'b0, 32'h0, 1'b0);
    do_upd(32'h108, 1'b1, 32'h400, 1'b1);
    do_upd(32'h10C, 1'b0, 32'h0, 1'b0);
    do_upd(32'h110, 1'b1, 32'h500, 1'b0);
    check_cnt("perf_branch_5", perf_branch_cnt, 32'd5);
    check_cnt("perf_mispred_2", perf_mispred_cnt, 32'd2);
    dut.perf_branch_cnt_q  = 32'hFFFF_FFFF;
    dut.perf_mispred_cnt_q = 32'hFFFF_FFFF;
    do_upd(32'h114, 1'b1, 32'h600, 1'b1);
    check_cnt("perf_branch_wrap", perf_branch_cnt, 32'd0);
    check_cnt("perf_mispred_wrap", perf_mispred_cnt, 32'd0);
`endif

    if (sb_q.size() != 0) begin
      total_cnt = total_cnt + 1;
      fail_cnt  = fail_cnt + 1;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
